// File: rtl/spm_banked_arb_pkg.sv
// Shared types and sizing helpers for the banked scratchpad and its banks.
package spm_banked_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic {
        CPU_PRIO   = 1'b0,
        DMA_FORCED = 1'b1
    } arb_state_e;

    // Write-side payload steered to a bank by the port mux
    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } spm_wr_t;

    function automatic int unsigned bank_bits(input int unsigned nr_banks);
        return (nr_banks > 1) ? $clog2(nr_banks) : 0;
    endfunction

    function automatic int unsigned cnt_bits(input int unsigned max_wait);
        return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
    endfunction

endpackage

// File: rtl/spm_banked_arb_bank.sv
// Single-port synchronous RAM bank, 32-bit words with byte-lane write enables.
module spm_banked_arb_bank
    import spm_banked_arb_pkg::*;
#(
    parameter  int unsigned WORDS = 512,
    localparam int unsigned ROW_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic [ROW_W-1:0]  row_i,
    input  spm_wr_t           wr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Read data only updates on a read, so a bank output holds between reads
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (wr_i.we) begin
                for (int b = 0; b < int'(BE_W); b++) begin
                    if (wr_i.be[b]) begin
                        mem_q[row_i][8*b +: 8] <= wr_i.wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[row_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spm_banked_arb.sv
// Word-interleaved multi-bank scratchpad with a CPU port and a DMA port;
// same-bank conflicts favour the CPU, with a wait counter that eventually forces the DMA through.
module spm_banked_arb
    import spm_banked_arb_pkg::*;
#(
    parameter  int unsigned NR_OF_BANKS    = 2,
    parameter  int unsigned WORDS_PER_BANK = 512,
    parameter  int unsigned MAX_DMA_WAIT   = 4,
    localparam int unsigned ADDR_BITS      = $clog2(NR_OF_BANKS * WORDS_PER_BANK)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cpu_cs_i,
    input  logic                 cpu_we_i,
    input  logic [ADDR_BITS-1:0] cpu_addr_i,
    input  logic [BE_W-1:0]      cpu_be_i,
    input  logic [DATA_W-1:0]    cpu_wdata_i,
    output logic [DATA_W-1:0]    cpu_rdata_o,
    output logic                 cpu_stall_o,
    input  logic                 dma_req_i,
    input  logic                 dma_we_i,
    input  logic [ADDR_BITS-1:0] dma_addr_i,
    input  logic [BE_W-1:0]      dma_be_i,
    input  logic [DATA_W-1:0]    dma_wdata_i,
    output logic                 dma_grant_o,
    output logic [DATA_W-1:0]    dma_rdata_o,
    output logic                 dma_rvalid_o
);

    localparam int unsigned BANK_BITS = bank_bits(NR_OF_BANKS);
    localparam int unsigned BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int unsigned ROW_W     = (WORDS_PER_BANK > 1) ? $clog2(WORDS_PER_BANK) : 1;
    localparam int unsigned CNT_W     = cnt_bits(MAX_DMA_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_DMA_WAIT);
    localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_BITS-1:0] a);
        return (NR_OF_BANKS > 1) ? BANK_W'(a) : '0;
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_BITS-1:0] a);
        return ROW_W'(a >> BANK_BITS);
    endfunction

    logic [BANK_W-1:0] cpu_bank, dma_bank;
    logic [ROW_W-1:0]  cpu_row, dma_row;
    spm_wr_t           cpu_wr, dma_wr;
    logic              conflict;

    assign cpu_bank = bank_of(cpu_addr_i);
    assign dma_bank = bank_of(dma_addr_i);
    assign cpu_row  = row_of(cpu_addr_i);
    assign dma_row  = row_of(dma_addr_i);
    assign cpu_wr   = '{we: cpu_we_i, be: cpu_be_i, wdata: cpu_wdata_i};
    assign dma_wr   = '{we: dma_we_i, be: dma_be_i, wdata: dma_wdata_i};
    assign conflict = cpu_cs_i & dma_req_i & (cpu_bank == dma_bank);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dma_grant, cpu_stall;

    // Arbiter next state; a forced cycle always lasts exactly one cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dma_grant = dma_req_i;
        cpu_stall = 1'b0;
        if (state_q == DMA_FORCED) begin
            state_d   = CPU_PRIO;
            cpu_stall = conflict;
        end else if (conflict) begin
            dma_grant = 1'b0;
            cnt_d     = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
            if ((MAX_DMA_WAIT != 0) && (cnt_d == CNT_MAX)) begin
                state_d = DMA_FORCED;
            end
        end
        if (dma_grant || (state_q == DMA_FORCED)) begin
            cnt_d = '0;
        end
    end

    assign dma_grant_o = dma_grant;
    assign cpu_stall_o = cpu_stall;

    logic              bank_en    [NR_OF_BANKS];
    logic [ROW_W-1:0]  bank_row   [NR_OF_BANKS];
    spm_wr_t           bank_wr    [NR_OF_BANKS];
    logic [DATA_W-1:0] bank_rdata [NR_OF_BANKS];

    // Per-bank port mux: at most one port ever selects a given bank in a cycle
    for (genvar b = 0; b < int'(NR_OF_BANKS); b++) begin : g_bank
        logic cpu_hit, dma_hit;
        assign cpu_hit     = cpu_cs_i & ~cpu_stall & (cpu_bank == BANK_W'(b));
        assign dma_hit     = dma_grant & (dma_bank == BANK_W'(b));
        assign bank_en[b]  = cpu_hit | dma_hit;
        assign bank_row[b] = dma_hit ? dma_row : cpu_row;
        assign bank_wr[b]  = dma_hit ? dma_wr : cpu_wr;

        spm_banked_arb_bank #(
            .WORDS (WORDS_PER_BANK)
        ) u_bank (
            .clk_i   (clk_i),
            .en_i    (bank_en[b]),
            .row_i   (bank_row[b]),
            .wr_i    (bank_wr[b]),
            .rdata_o (bank_rdata[b])
        );
    end

    logic              cpu_rd_acc, dma_rd_acc;
    logic              cpu_rd_pend_q, dma_rd_pend_q;
    logic [BANK_W-1:0] cpu_rd_bank_q, dma_rd_bank_q;
    logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

    assign cpu_rd_acc = cpu_cs_i & ~cpu_we_i & ~cpu_stall;
    assign dma_rd_acc = dma_grant & ~dma_we_i;

    // Arbiter state plus return tags; hold registers capture bank data so later accesses can't disturb it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= CPU_PRIO;
            cnt_q         <= '0;
            cpu_rd_pend_q <= 1'b0;
            dma_rd_pend_q <= 1'b0;
            cpu_rd_bank_q <= '0;
            dma_rd_bank_q <= '0;
            cpu_rdata_q   <= '0;
            dma_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cpu_rd_pend_q <= cpu_rd_acc;
            dma_rd_pend_q <= dma_rd_acc;
            if (cpu_rd_acc) cpu_rd_bank_q <= cpu_bank;
            if (dma_rd_acc) dma_rd_bank_q <= dma_bank;
            if (cpu_rd_pend_q) cpu_rdata_q <= bank_rdata[cpu_rd_bank_q];
            if (dma_rd_pend_q) dma_rdata_q <= bank_rdata[dma_rd_bank_q];
        end
    end

    assign cpu_rdata_o  = cpu_rd_pend_q ? bank_rdata[cpu_rd_bank_q] : cpu_rdata_q;
    assign dma_rdata_o  = dma_rd_pend_q ? bank_rdata[dma_rd_bank_q] : dma_rdata_q;
    assign dma_rvalid_o = dma_rd_pend_q;

endmodule

// File: tb/tb_spm_banked_arb.sv
// Scoreboard bench for spm_banked_arb: two instances share stimulus, one with the DMA guard on and one with it off.
module tb_spm_banked_arb;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_cs, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [3:0]    cpu_be, dma_be;
    logic [31:0]   cpu_wd, dma_wd;

    logic [31:0] cpu_rdata, dma_rdata, c0_cpu_rdata, c0_dma_rdata;
    logic        cpu_stall, dma_grant, dma_rvalid;
    logic        c0_cpu_stall, c0_dma_grant, c0_dma_rvalid;

    always #5 clk = ~clk;

    spm_banked_arb #(.NR_OF_BANKS(2), .WORDS_PER_BANK(512), .MAX_DMA_WAIT(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_cs_i(cpu_cs), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_be_i(cpu_be),
        .cpu_wdata_i(cpu_wd), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_be_i(dma_be),
        .dma_wdata_i(dma_wd), .dma_grant_o(dma_grant), .dma_rdata_o(dma_rdata),
        .dma_rvalid_o(dma_rvalid)
    );

    spm_banked_arb #(.NR_OF_BANKS(2), .WORDS_PER_BANK(512), .MAX_DMA_WAIT(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_cs_i(cpu_cs), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_be_i(cpu_be),
        .cpu_wdata_i(cpu_wd), .cpu_rdata_o(c0_cpu_rdata), .cpu_stall_o(c0_cpu_stall),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_be_i(dma_be),
        .dma_wdata_i(dma_wd), .dma_grant_o(c0_dma_grant), .dma_rdata_o(c0_dma_rdata),
        .dma_rvalid_o(c0_dma_rvalid)
    );

    typedef struct {
        logic [31:0] val;
        bit          any;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        cpu_q[$];
    logic [31:0] dma_q[$];
    logic        cpu_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: an accepted CPU read is seen at the edge, its data compared half a cycle later
    always @(posedge clk) cpu_chk <= rst_n & cpu_cs & ~cpu_we & ~cpu_stall;

    always @(negedge clk) begin
        exp_t e;
        if (cpu_chk) begin
            if (cpu_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL cpu_rd_unexpected: got %h, expected no read", cpu_rdata);
            end else begin
                e = cpu_q.pop_front();
                if (e.any) begin
                    checks++;
                    if ($isunknown(cpu_rdata)) begin
                        errors++;
                        $display("FAIL cpu_rd_known: got %h, expected no X", cpu_rdata);
                    end
                end else begin
                    chk("cpu_rd", cpu_rdata, e.val);
                end
            end
        end
        if (dma_rvalid) begin
            if (dma_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL dma_rvalid_unexpected: got pulse with data %h, expected none", dma_rdata);
            end else begin
                chk("dma_rd", dma_rdata, dma_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_cs = 0; cpu_we = 0; cpu_addr = '0; cpu_be = '0; cpu_wd = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_be = '0; dma_wd = '0;
    endtask

    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
        idle();
        cpu_cs = 1; cpu_we = we; cpu_addr = a; cpu_wd = wd; cpu_be = be;
        step();
    endtask

    task automatic cpu_rd(input logic [AW-1:0] a, input logic [31:0] exp);
        cpu_q.push_back('{exp, 1'b0});
        cpu_op(1'b0, a, '0, '0);
    endtask

    task automatic set_dma(input logic we, input logic [AW-1:0] a, input logic [31:0] wd);
        dma_req = 1; dma_we = we; dma_addr = a; dma_wd = wd; dma_be = 4'hF;
    endtask

    // One non-conflicting DMA grant: leaves the arbiter idle with a cleared wait count
    task automatic sync();
        idle();
        dma_req = 1; dma_we = 1; dma_addr = 10'd1023; dma_be = 4'h0;
        step();
    endtask

    initial begin
        idle();
        rst_n = 0;
        // Reset with random inputs: registered outputs stay zero
        repeat (4) begin
            cpu_cs = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = AW'($urandom);
            cpu_be = 4'($urandom); cpu_wd = $urandom;
            dma_req = 1'($urandom); dma_we = 1'($urandom); dma_addr = AW'($urandom);
            dma_be = 4'($urandom); dma_wd = $urandom;
            @(negedge clk);
            chk("rst_cpu_rdata", cpu_rdata, 32'h0);
            chk("rst_dma_rdata", dma_rdata, 32'h0);
            chk("rst_dma_rvalid", 32'(dma_rvalid), 32'h0);
            step();
        end
        idle();
        rst_n = 1;
        step();

        cpu_q.push_back('{32'h0, 1'b1});
        cpu_op(1'b0, 10'd0, '0, '0);

        // Byte-lane merge
        cpu_op(1'b1, 10'd5, 32'hAABB_CCDD, 4'hF);
        cpu_op(1'b1, 10'd5, 32'h1122_3344, 4'b0101);
        cpu_rd(10'd5, 32'hAA22_CC44);

        // Preloads used by the arbitration tests (all bank 0)
        cpu_op(1'b1, 10'd2,  32'h0000_2222, 4'hF);
        cpu_op(1'b1, 10'd4,  32'h4444_4444, 4'hF);
        cpu_op(1'b1, 10'd6,  32'h6666_6666, 4'hF);
        cpu_op(1'b1, 10'd10, 32'h1010_1010, 4'hF);

        // Parallel banks: CPU reads bank 0 while DMA writes bank 1
        for (int i = 0; i < 8; i++) begin
            idle();
            cpu_cs = 1; cpu_addr = 10'd2;
            set_dma(1'b1, 10'd3, 32'h3000_0000 + 32'(i));
            cpu_q.push_back('{32'h0000_2222, 1'b0});
            @(negedge clk);
            chk("par_grant", 32'(dma_grant), 32'h1);
            chk("par_stall", 32'(cpu_stall), 32'h0);
            step();
        end
        // DMA read bank 1 alongside a CPU write to bank 0
        idle();
        cpu_cs = 1; cpu_we = 1; cpu_addr = 10'd4; cpu_wd = 32'h4444_4444; cpu_be = 4'hF;
        set_dma(1'b0, 10'd3, '0);
        dma_q.push_back(32'h3000_0007);
        @(negedge clk);
        chk("par_rd_grant", 32'(dma_grant), 32'h1);
        step();
        sync();

        // Starvation guard vs guard-off instance on identical conflicting traffic
        for (int i = 0; i < 100; i++) begin
            logic g;
            g = ((i % 5) == 4);
            idle();
            cpu_cs = 1; cpu_addr = 10'd4;
            set_dma(1'b0, 10'd6, '0);
            if (g) dma_q.push_back(32'h6666_6666);
            else   cpu_q.push_back('{32'h4444_4444, 1'b0});
            @(negedge clk);
            chk("starve_grant", 32'(dma_grant), 32'(g));
            chk("starve_stall", 32'(cpu_stall), 32'(g));
            chk("guard_off_grant", 32'(c0_dma_grant), 32'h0);
            chk("guard_off_stall", 32'(c0_cpu_stall), 32'h0);
            step();
        end

        // Conflict vanishes in the forced cycle: counter must restart from zero
        for (int i = 0; i < 10; i++) begin
            logic g, drop;
            drop = (i == 4);
            g    = (i == 9);
            idle();
            cpu_cs = 1; cpu_addr = 10'd4;
            if (!drop) set_dma(1'b0, 10'd6, '0);
            if (g) dma_q.push_back(32'h6666_6666);
            else   cpu_q.push_back('{32'h4444_4444, 1'b0});
            @(negedge clk);
            chk("drop_grant", 32'(dma_grant), 32'(g));
            chk("drop_stall", 32'(cpu_stall), 32'(g));
            step();
        end

        // Stalled CPU write must not land
        for (int i = 0; i < 5; i++) begin
            logic g;
            g = (i == 4);
            idle();
            cpu_cs = 1; cpu_we = 1; cpu_addr = 10'd8; cpu_be = 4'hF;
            cpu_wd = 32'hC0DE_0000 + 32'(i);
            set_dma(1'b0, 10'd10, '0);
            if (g) dma_q.push_back(32'h1010_1010);
            @(negedge clk);
            chk("wstall_stall", 32'(cpu_stall), 32'(g));
            step();
        end
        cpu_rd(10'd8, 32'hC0DE_0003);
        cpu_op(1'b1, 10'd8, 32'hDEAD_BEEF, 4'hF);
        idle();
        @(negedge clk);
        chk("rdata_hold_on_write", cpu_rdata, 32'hC0DE_0003);
        step();

        // Reset right after a granted DMA read: the read-valid is dropped
        idle();
        set_dma(1'b0, 10'd3, '0);
        @(negedge clk);
        chk("rst_mid_grant", 32'(dma_grant), 32'h1);
        #1;
        idle();
        rst_n = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_rvalid", 32'(dma_rvalid), 32'h0);
            chk("rst_mid_rdata", dma_rdata, 32'h0);
        end
        step();
        rst_n = 1;
        step();
        cpu_rd(10'd5, 32'hAA22_CC44);
        idle();
        set_dma(1'b0, 10'd3, '0);
        dma_q.push_back(32'h3000_0007);
        step();
        idle();
        repeat (3) step();

        chk("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
        chk("dma_q_drained", 32'(dma_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
